// File: rtl/op_sequencer_pkg.sv
// opseq_pkg: shared ALU op codes, last-op codes and sequencer state encoding.
package opseq_pkg;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MULT = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;
  localparam logic [2:0] LAST_NONE = 3'b000;
  localparam logic [2:0] LAST_ADD = 3'b001;
  localparam logic [2:0] LAST_SUB = 3'b010;
  localparam logic [2:0] LAST_MULT = 3'b011;
  localparam logic [2:0] LAST_DIV = 3'b100;
  localparam logic [2:0] LAST_PREV = 3'b101;
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_COMMIT, S_SHOW, S_RECALL, S_ERR} state_t;
  function automatic logic [2:0] last_of(input logic [1:0] op);
    return {1'b0, op} + 3'd1;
  endfunction
endpackage

// File: rtl/op_sequencer_if.sv
// op_sequencer_if: button/switch inputs and ALU/register/display controls of the op sequencer.
interface op_sequencer_if;
  logic btn_add;
  logic btn_sub;
  logic btn_mult;
  logic btn_div;
  logic btn_prev;
  logic write_en;
  logic [7:0] operand_b;
  logic [1:0] alu_op;
  logic reg_read;
  logic reg_write;
  logic switch_input;
  logic busy;
  logic err;
  logic [2:0] last_op;
  modport master (
    output btn_add, btn_sub, btn_mult, btn_div, btn_prev, write_en, operand_b,
    input alu_op, reg_read, reg_write, switch_input, busy, err, last_op
  );
  modport slave (
    input btn_add, btn_sub, btn_mult, btn_div, btn_prev, write_en, operand_b,
    output alu_op, reg_read, reg_write, switch_input, busy, err, last_op
  );
endinterface

// File: rtl/op_sequencer_btn_conditioner.sv
// btn_conditioner: 2-flop synchronizer, optional debounce (OPSEQ_DEBOUNCE_EN), one-clock rising-edge pulse.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  logic [1:0] sync;
  logic lvl, lvl_d;
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= '0;
    else sync <= {sync[0], btn};
`ifdef OPSEQ_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DW-1:0] cnt;
  // level moves only after the synced input has disagreed with it for DEBOUNCE_CYCLES clocks in a row
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else if (sync[1] == lvl) cnt <= '0;
    else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      lvl <= sync[1];
      cnt <= '0;
    end else cnt <= cnt + 1'b1;
`else
  assign lvl = sync[1];
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) lvl_d <= 1'b0;
    else lvl_d <= lvl;
  assign pulse = lvl & ~lvl_d;
endmodule

// File: rtl/op_sequencer.sv
// op_sequencer: arbitrates button requests into one ALU op / commit / display-hold sequence at a time.
// Define OPSEQ_DEBOUNCE_EN to debounce the buttons for DEBOUNCE_CYCLES clocks.
module op_sequencer
  import opseq_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int SHOW_CYCLES = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic clk,
  input logic reset,
  op_sequencer_if.slave bus
);
  localparam int CW = $clog2((SHOW_CYCLES > ALU_LAT ? SHOW_CYCLES : ALU_LAT) + 1);
  if (ALU_LAT < 1 || SHOW_CYCLES < 1) begin : g_bad_cfg
    $error("ALU_LAT and SHOW_CYCLES must be at least 1");
  end
  logic [4:0] btn, req;
  logic [1:0] we_s;
  logic [1:0] op;
  logic op_req, idle_like;
  logic [CW-1:0] cnt;
  state_t state;
  assign btn = {bus.btn_prev, bus.btn_div, bus.btn_mult, bus.btn_sub, bus.btn_add};
  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk(clk), .reset(reset), .btn(btn[i]), .pulse(req[i])
    );
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) we_s <= '0;
    else we_s <= {we_s[0], bus.write_en};
  always_comb begin
    op_req = |req[3:0];
    op = req[3] ? ALU_DIV : req[2] ? ALU_MULT : req[1] ? ALU_SUB : ALU_ADD;
    idle_like = state == S_IDLE || state == S_SHOW || state == S_ERR;
  end
  // SHOW and ERR accept a new request exactly like IDLE, which aborts the hold
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      bus.alu_op <= ALU_ADD;
      bus.reg_read <= 1'b0;
      bus.reg_write <= 1'b0;
      bus.switch_input <= 1'b1;
      bus.busy <= 1'b0;
      bus.err <= 1'b0;
      bus.last_op <= LAST_NONE;
    end else begin
      bus.reg_write <= 1'b0;
      if (idle_like && (req[4] || op_req)) begin
        bus.busy <= 1'b1;
        bus.switch_input <= 1'b1;
        if (req[4]) begin
          state <= S_RECALL;
          bus.reg_read <= 1'b1;
          bus.err <= 1'b0;
          bus.last_op <= LAST_PREV;
        end else if (op == ALU_DIV && bus.operand_b == 8'd0) begin
          state <= S_ERR;
          bus.reg_read <= 1'b0;
          bus.err <= 1'b1;
          bus.last_op <= LAST_DIV;
          cnt <= CW'(SHOW_CYCLES - 1);
        end else begin
          state <= S_EXEC;
          bus.reg_read <= 1'b0;
          bus.err <= 1'b0;
          bus.alu_op <= op;
          bus.last_op <= last_of(op);
          cnt <= CW'(ALU_LAT - 1);
        end
      end else
        case (state)
          S_EXEC:
            if (cnt == '0) begin
              state <= S_COMMIT;
              bus.reg_write <= we_s[1];
            end else cnt <= cnt - 1'b1;
          S_COMMIT, S_RECALL: begin
            state <= S_SHOW;
            bus.switch_input <= 1'b0;
            cnt <= CW'(SHOW_CYCLES - 1);
          end
          S_SHOW, S_ERR:
            if (cnt == '0) begin
              state <= S_IDLE;
              bus.busy <= 1'b0;
              bus.switch_input <= 1'b1;
              bus.reg_read <= 1'b0;
              bus.err <= 1'b0;
            end else cnt <= cnt - 1'b1;
          default: ;
        endcase
    end
endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer: table-driven plus hand-sequenced checks of op_sequencer with ALU_LAT=1, SHOW_CYCLES=8.
module tb_op_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  op_sequencer_if bus();
  op_sequencer #(.ALU_LAT(1), .SHOW_CYCLES(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  typedef struct {
    logic [4:0] btn;
    logic we;
    logic [7:0] b;
    int alu, last, wr, rd, er, sw0, busy, fb, fw;
  } vec_t;
  vec_t vt[10];
  int passed = 0, total = 0;
  int k, wr_c, rd_c, er_c, sw0_c, busy_c, fb, fw;
  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask
  task automatic drive(input logic [4:0] b);
    {bus.btn_prev, bus.btn_div, bus.btn_mult, bus.btn_sub, bus.btn_add} = b;
  endtask
  task automatic clr();
    k = 0; wr_c = 0; rd_c = 0; er_c = 0; sw0_c = 0; busy_c = 0; fb = 0; fw = 0;
  endtask
  task automatic tick();
    @(negedge clk);
    k++;
    if (bus.reg_write) begin wr_c++; if (fw == 0) fw = k; end
    if (bus.reg_read) rd_c++;
    if (bus.err) er_c++;
    if (!bus.switch_input) sw0_c++;
    if (bus.busy) begin busy_c++; if (fb == 0) fb = k; end
  endtask
  initial begin
    // btn = {prev, div, mult, sub, add}
    vt[0] = '{5'b00001, 1'b1, 8'd1, 0, 1, 1, 0, 0, 8, 10, 3, 4};
    vt[1] = '{5'b00110, 1'b1, 8'd1, 2, 3, 1, 0, 0, 8, 10, 3, 4};
    vt[2] = '{5'b01000, 1'b1, 8'd0, 2, 4, 0, 0, 8, 0, 8, 3, 0};
    vt[3] = '{5'b01000, 1'b1, 8'd5, 3, 4, 1, 0, 0, 8, 10, 3, 4};
    vt[4] = '{5'b00100, 1'b0, 8'd5, 2, 3, 0, 0, 0, 8, 10, 3, 0};
    vt[5] = '{5'b10000, 1'b1, 8'd5, 2, 5, 0, 9, 0, 8, 9, 3, 0};
    vt[6] = '{5'b10001, 1'b1, 8'd5, 2, 5, 0, 9, 0, 8, 9, 3, 0};
    vt[7] = '{5'b00010, 1'b1, 8'd0, 1, 2, 1, 0, 0, 8, 10, 3, 4};
    vt[8] = '{5'b01100, 1'b1, 8'd0, 1, 4, 0, 0, 8, 0, 8, 3, 0};
    vt[9] = '{5'b11111, 1'b1, 8'd0, 1, 5, 0, 9, 0, 8, 9, 3, 0};
    drive(5'b0);
    bus.write_en = 1'b0;
    bus.operand_b = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_alu_op", int'(bus.alu_op), 0);
    check("rst_reg_read", int'(bus.reg_read), 0);
    check("rst_reg_write", int'(bus.reg_write), 0);
    check("rst_switch_input", int'(bus.switch_input), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_last_op", int'(bus.last_op), 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clr();
      drive(vt[i].btn);
      bus.write_en = vt[i].we;
      bus.operand_b = vt[i].b;
      for (int c = 0; c < 24; c++) begin
        tick();
        if (k == 3) drive(5'b0);
      end
      check($sformatf("v%0d_alu_op", i), int'(bus.alu_op), vt[i].alu);
      check($sformatf("v%0d_last_op", i), int'(bus.last_op), vt[i].last);
      check($sformatf("v%0d_reg_write_cnt", i), wr_c, vt[i].wr);
      check($sformatf("v%0d_reg_read_cnt", i), rd_c, vt[i].rd);
      check($sformatf("v%0d_err_cnt", i), er_c, vt[i].er);
      check($sformatf("v%0d_show_cnt", i), sw0_c, vt[i].sw0);
      check($sformatf("v%0d_busy_cnt", i), busy_c, vt[i].busy);
      check($sformatf("v%0d_busy_first", i), fb, vt[i].fb);
      check($sformatf("v%0d_write_first", i), fw, vt[i].fw);
    end
    // re-press add while the first result is on display: hold aborts, second op runs
    clr();
    drive(5'b00001);
    bus.write_en = 1'b1;
    bus.operand_b = 8'd1;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (k == 1) drive(5'b0);
      if (k == 6) drive(5'b00001);
      if (k == 7) drive(5'b0);
      if (k == 9) check("abort_switch_exec", int'(bus.switch_input), 1);
      if (k == 10) check("abort_commit_write", int'(bus.reg_write), 1);
    end
    check("abort_reg_write_cnt", wr_c, 2);
    check("abort_show_cnt", sw0_c, 12);
    check("abort_last_op", int'(bus.last_op), 1);
    // sub request lands while add is in EXEC and must be dropped
    clr();
    drive(5'b00001);
    for (int c = 0; c < 24; c++) begin
      tick();
      if (k == 1) drive(5'b00010);
      if (k == 5) drive(5'b0);
    end
    check("exec_ignore_write_cnt", wr_c, 1);
    check("exec_ignore_alu_op", int'(bus.alu_op), 0);
    check("exec_ignore_last_op", int'(bus.last_op), 1);
    check("exec_ignore_busy_cnt", busy_c, 10);
    // add held for 20 clocks yields one sequence only
    clr();
    drive(5'b00001);
    for (int c = 0; c < 32; c++) begin
      tick();
      if (k == 20) drive(5'b0);
    end
    check("held_write_cnt", wr_c, 1);
    check("held_busy_cnt", busy_c, 10);
    check("held_busy_first", fb, 3);
    // async reset between edges while in EXEC
    clr();
    drive(5'b00100);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (k == 1) drive(5'b0);
    end
    check("mid_exec_busy", int'(bus.busy), 1);
    check("mid_exec_alu_op", int'(bus.alu_op), 2);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_alu_op", int'(bus.alu_op), 0);
    check("async_rst_last_op", int'(bus.last_op), 0);
    check("async_rst_switch_input", int'(bus.switch_input), 1);
    check("async_rst_reg_write", int'(bus.reg_write), 0);
    check("async_rst_reg_read", int'(bus.reg_read), 0);
    check("async_rst_err", int'(bus.err), 0);
    @(negedge clk);
    reset = 1'b0;
    clr();
    for (int c = 0; c < 12; c++) tick();
    check("post_rst_write_cnt", wr_c, 0);
    check("post_rst_busy_cnt", busy_c, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/op_sequencer.md
Name: op_sequencer

Overview:
Front-end controller for the 8-bit ALU / result register / 7-segment display path. It turns raw push-button requests (add, sub, mult, div, prev) into one sequenced operation at a time: it drives alu_op, waits for the ALU, commits the result to the register, then holds the display in result mode for a fixed time. Fixed-priority arbitration resolves simultaneous presses, divide-by-zero is trapped, and the block sits between the board buttons and the ALU/Register/time-multiplexer instances in TOP.

Parameters:
ALU_LAT, 1, clocks the ALU result must settle after alu_op changes (min 1)
SHOW_CYCLES, 50_000_000, clocks the result stays on the display (0.5 s at 100 MHz; min 1)
DEBOUNCE_CYCLES, 1_000_000, stable-level clocks required per button (used only with OPSEQ_DEBOUNCE_EN)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_add  input  1  raw add button
btn_sub  input  1  raw subtract button
btn_mult  input  1  raw multiply button
btn_div  input  1  raw divide button
btn_prev  input  1  raw recall-previous button
write_en  input  1  level switch; 1 = commit result to register
operand_b  input  8  B operand, used only for divide-by-zero check
alu_op  output  2  00 add, 01 sub, 10 mult, 11 div
reg_read  output  1  register read strobe
reg_write  output  1  register write strobe, one clock
switch_input  output  1  1 = display operands, 0 = display result
busy  output  1  high in every state except IDLE
err  output  1  divide-by-zero indication
last_op  output  3  000 none, 001 add, 010 sub, 011 mult, 100 div, 101 prev

Behaviour:
- Reset (async, any state): state=IDLE, alu_op=00, reg_read=0, reg_write=0, switch_input=1, busy=0, err=0, last_op=000, all counters and sync flops cleared.
- Each button: 2-flop synchronizer, then rising-edge detect giving a one-clock request. FSM leaves IDLE on the 3rd clock edge after the first edge that samples the raw button high.
- Priority on the same cycle: prev > div > mult > sub > add; lower requests in that cycle are dropped.
- States: IDLE, EXEC, COMMIT, SHOW, RECALL, ERR.
- IDLE: switch_input=1. On an op request, latch alu_op and last_op, go to EXEC. If div is requested with operand_b==0, go to ERR instead (last_op=100, alu_op unchanged). On prev, go to RECALL.
- EXEC: hold alu_op for ALU_LAT clocks, then go to COMMIT.
- COMMIT: exactly one clock. reg_write = write_en sampled this cycle. Then go to SHOW.
- RECALL: exactly one clock with reg_read=1, last_op=101, then go to SHOW.
- SHOW: switch_input=0. Down-count SHOW_CYCLES, then go to IDLE. reg_read stays 1 during SHOW only when entered from RECALL.
- ERR: err=1, switch_input=1, no register access. Hold SHOW_CYCLES, then go to IDLE with err=0.
- Requests arriving in EXEC, COMMIT or RECALL are discarded, not queued.
- A new request arriving in SHOW or ERR aborts the hold and is processed as if in IDLE on the same edge.
- A button held down produces one request only; release and re-press is needed.
- alu_op and last_op hold their values after returning to IDLE.

Optional Feature:
OPSEQ_DEBOUNCE_EN
- Defined: after the synchronizer, each button's level must stay stable for DEBOUNCE_CYCLES clocks before the debounced level updates. Edge detect acts on the debounced level, adding DEBOUNCE_CYCLES clocks of latency.
- Undefined: no debounce; synchronizer plus edge detect only (3-clock latency).

Decomposition:
- Shared package opseq_pkg: ALU_ADD/SUB/MULT/DIV 2-bit constants, LAST_* 3-bit codes, state encoding constants.
- One sub-module, btn_conditioner (synchronizer, optional debounce, rising-edge pulse), instantiated five times; write_en gets the 2-flop synchronizer only.

Test Plan:
(Bench settings: ALU_LAT=1, SHOW_CYCLES=8, debounce off.)
- Reset, then btn_add pulse with write_en=1: alu_op=00, busy rises 3 clocks after the button, one reg_write pulse after 1 EXEC clock, switch_input=0 for 8 clocks, then IDLE, last_op=001.
- btn_sub and btn_mult asserted on the same edge: only mult runs (alu_op=10, last_op=011), one reg_write, no sub sequence follows.
- btn_div with operand_b=0: err=1 for 8 clocks, reg_write never asserts, switch_input stays 1, last_op=100.
- btn_mult with write_en=0, then btn_prev: no reg_write; RECALL gives reg_read=1 through SHOW, last_op=101.
- btn_add in SHOW aborts it and restarts EXEC; btn_sub during EXEC is ignored; btn_add held 20 clocks gives exactly one sequence.
- reset asserted mid-EXEC (async, between clock edges): all outputs return to reset values immediately; no reg_write.
